// File: rtl/comb_add_pkg.sv
// comb_add_pkg: shared default operand width for the modular adder
package comb_add_pkg;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/comb_add_fa.sv
// comb_add_fa: one-bit full adder cell
module comb_add_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/comb_add.sv
// comb_add: combinational ripple-carry adder, sum modulo 2^WIDTH
module comb_add
  import comb_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);
  logic [WIDTH:0] cy;
  logic           unused;
  assign cy[0]  = 1'b0;
  assign unused = ^{clk, rst, cy[WIDTH]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    comb_add_fa u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (cy[i]),
      .s  (c[i]),
      .co (cy[i+1])
    );
  end
endmodule

// File: tb/tb_comb_add.sv
// tb_comb_add: self-checking bench for comb_add against an arithmetic model
module tb_comb_add;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] c;
  int tests = 0;
  int fails = 0;

  comb_add #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c));

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input int x, input int y);
    return 4'((x + y) % 16);
  endfunction

  task automatic apply(input int x, input int y);
    a = 4'(x);
    b = 4'(y);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    apply(1, 2);
    tests++;
    if (c !== 4'd3) begin
      fails++;
      $display("FAIL reset_hold: c=%0d expected=3", c);
    end
    rst = 1'b0;
    #2;
  endtask

  task automatic test_passthrough;
    apply(0, 5);
    tests++;
    if (c !== 4'd5) begin
      fails++;
      $display("FAIL passthrough: c=%0d expected=5", c);
    end
    apply(9, 0);
    tests++;
    if (c !== 4'd9) begin
      fails++;
      $display("FAIL passthrough_b0: c=%0d expected=9", c);
    end
  endtask

  task automatic test_wrap;
    apply(15, 10);
    tests++;
    if (c !== 4'd9) begin
      fails++;
      $display("FAIL wrap: c=%0d expected=9", c);
    end
  endtask

  task automatic test_max;
    apply(15, 1);
    tests++;
    if (c !== 4'd0) begin
      fails++;
      $display("FAIL max_15_1: c=%0d expected=0", c);
    end
    apply(15, 15);
    tests++;
    if (c !== 4'd14) begin
      fails++;
      $display("FAIL max_15_15: c=%0d expected=14", c);
    end
  endtask

  task automatic test_rst_clk;
    apply(7, 8);
    for (int t = 0; t < 40; t++) begin
      if (t == 7)  rst = 1'b1;
      if (t == 18) rst = 1'b0;
      if (t == 29) rst = 1'b1;
      #1;
      tests++;
      if (c !== 4'd15) begin
        fails++;
        $display("FAIL rst_clk t=%0d rst=%0b clk=%0b: c=%0d expected=15", t, rst, clk, c);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        apply(x, y);
        tests++;
        if (c !== model(x, y)) begin
          fails++;
          $display("FAIL sweep a=%0d b=%0d: c=%0d expected=%0d", x, y, c, model(x, y));
        end
      end
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      int x = int'($urandom_range(15, 0));
      int y = int'($urandom_range(15, 0));
      rst = $urandom_range(1, 0) == 1;
      apply(x, y);
      tests++;
      if (c !== model(x, y)) begin
        fails++;
        $display("FAIL random a=%0d b=%0d rst=%0b: c=%0d expected=%0d", x, y, rst, c, model(x, y));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2;
    test_reset;
    test_passthrough;
    test_wrap;
    test_max;
    test_rst_clk;
    test_sweep;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comb_add.md
Name: comb_add

Overview:
- Purely combinational modular adder: c = (a + b) mod 2^WIDTH, carry-out discarded.
- Used as a leaf datapath block. Carries the standard clock/reset pair for interface uniformity; the datapath does not use them.
- Output tracks inputs with zero clock latency. It is valid within one simulation time unit of any input change, regardless of clock or reset state.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 1).

Ports:
- clk  input  1      system clock; present for interface uniformity, unused by datapath.
- rst  input  1      asynchronous, active-high reset; does not gate or alter c.
- a    input  WIDTH  first operand, unsigned.
- b    input  WIDTH  second operand, unsigned.
- c    output WIDTH  sum, unsigned, modulo 2^WIDTH.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- c = (a + b) truncated to WIDTH bits. There is no carry-out port and no saturation. Overflow wraps, e.g. WIDTH=4: 15+10 -> 9.
- Fully combinational:
  - no registers on the a/b -> c path;
  - no dependence on clk edges;
  - zero-cycle latency.
- Settling: c reflects new a/b after delta-cycle propagation only. It must be stable before 1 time unit elapses.
- Reset:
  - rst has no effect on c. c is correct while rst=1 and while rst=0.
  - There is no reset value for c; it is always the function of the current a/b.
  - Asserting or deasserting rst mid-operation changes nothing.
- Unknown inputs: if any bit of a or b is X/Z, c may be X. No X-masking is required.
- Implementation: a WIDTH-bit ripple-carry chain of full-adder cells. Carry-in to bit 0 is 0; the final carry-out is left unconnected. A behavioural "+" is an acceptable alternative provided the results are bit-identical.
- Lint: clk and rst are intentionally unused. Waive the corresponding unused-input warnings locally.

Decomposition:
- Shared package: none required. WIDTH is local to the instance, and there are no typedefs.
- Sub-module: comb_add_fa (1-bit full adder: inputs x, y, ci; outputs s, co), instantiated WIDTH times via generate.

Test Plan:
- rst=1 held, a=1, b=2 -> after 1 time unit, c=3 (reset does not suppress output).
- a=0, b=5 -> c=5 (zero operand passthrough).
- a=15, b=10 -> c=9 (wrap-around, carry-out dropped).
- a=15, b=1 -> c=0; a=15, b=15 -> c=14 (maximum overflow cases).
- rst toggled 1->0->1 and clk running, with a=7, b=8 held -> c remains 15 throughout, with no glitch tied to clk or rst edges.
- Exhaustive sweep for WIDTH=4: all 256 (a,b) pairs -> c == (a+b)&4'hF, each checked 1 time unit after application.
